// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture
//   Captures the OV7670 8-bit parallel bus and turns byte pairs into RGB444 pixels,
//   with pixel coordinates, start-of-frame, frame-done and line-length error reporting.
//   Optional macro CAPTURE_TESTPAT_EN replaces camera pixel data with a coordinate
//   test pattern {x[7:4], y[7:4], x[7:4]^y[7:4]}; timing and flags are unchanged.
//
// Ports:
//   i_clk         camera PCLK, rising edge
//   i_rstn        asynchronous active-low reset
//   i_cfg_done    SCCB configuration complete; capture held off while low
//   i_vsync       VSYNC, high = vertical blanking
//   i_href        HREF, high = valid byte on i_data
//   i_data        camera data byte
//   o_pix_data    RGB444 pixel {R,G,B}
//   o_pix_valid   one-cycle strobe for o_pix_data
//   o_x, o_y      coordinates of the pixel on o_pix_data
//   o_sof         first pixel of a frame (x=0, y=0), with o_pix_valid
//   o_frame_done  pulse on VSYNC rise that ends an active frame
//   o_line_err    pulse after a line whose byte count was not 2*IMG_W
`timescale 1ns/1ps
module ov7670_pixel_capture #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_cfg_done,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_data,
  output logic [11:0] o_pix_data,
  output logic        o_pix_valid,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_sof,
  output logic        o_frame_done,
  output logic        o_line_err
);

  localparam int unsigned XW         = 10;
  localparam int unsigned YW         = 9;
  localparam int unsigned LINE_BYTES = 2 * IMG_W;
  // Byte counter saturates one past a legal line so long lines stay flagged.
  localparam int unsigned BCW        = $clog2(LINE_BYTES + 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           vsync_q, vsync_qq, href_q, href_qq;
  logic [7:0]     data_q;
  logic           phase_q, phase_d;
  logic [3:0]     red_q, red_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [11:0]    pix_data_q, pix_data_d;
  logic           pix_valid_q, pix_valid_d;
  logic [XW-1:0]  ox_q, ox_d;
  logic [YW-1:0]  oy_q, oy_d;
  logic           sof_q, sof_d;
  logic           fdone_q, fdone_d;
  logic           lerr_q, lerr_d;

  logic           vsync_rise, vsync_fall, href_fall, byte_en;
  logic [11:0]    pix_new;

  // Edge detects on the registered camera signals
  assign vsync_rise = vsync_q & ~vsync_qq;
  assign vsync_fall = ~vsync_q & vsync_qq;
  assign href_fall  = ~href_q & href_qq;
  // HREF is meaningless during vertical blanking
  assign byte_en    = href_q & ~vsync_q;

`ifdef CAPTURE_TESTPAT_EN
  assign pix_new = {x_q[7:4], y_q[7:4], x_q[7:4] ^ y_q[7:4]};
`else
  assign pix_new = {red_q, data_q};
`endif

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    red_d       = red_q;
    x_d         = x_q;
    y_d         = y_q;
    bcnt_d      = bcnt_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    ox_d        = ox_q;
    oy_d        = oy_q;
    sof_d       = 1'b0;
    fdone_d     = 1'b0;
    lerr_d      = 1'b0;

    if (!i_cfg_done) begin
      state_d = S_IDLE;
      phase_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_WAIT;
        // Only a fresh VSYNC fall starts a frame; a frame already running is skipped
        S_WAIT: begin
          if (vsync_fall) begin
            state_d = S_ACTIVE;
            phase_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
            bcnt_d  = '0;
          end
        end
        S_ACTIVE: begin
          if (vsync_rise) begin
            // Frame end wins over any coincident byte; half pixel is dropped
            fdone_d = 1'b1;
            state_d = S_WAIT;
            phase_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
            bcnt_d  = '0;
          end else if (byte_en) begin
            if (bcnt_q != BCW'(LINE_BYTES + 1)) bcnt_d = bcnt_q + BCW'(1);
            if (!phase_q) begin
              red_d   = data_q[3:0];
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if ((x_q < XW'(IMG_W)) && (y_q < YW'(IMG_H))) begin
                pix_data_d  = pix_new;
                pix_valid_d = 1'b1;
                ox_d        = x_q;
                oy_d        = y_q;
                sof_d       = (x_q == '0) && (y_q == '0);
                x_d         = x_q + XW'(1);
              end
            end
          end else if (href_fall && (bcnt_q != '0)) begin
            // Line end: odd trailing byte is discarded with the phase reset
            lerr_d  = (bcnt_q != BCW'(LINE_BYTES));
            phase_d = 1'b0;
            x_d     = '0;
            bcnt_d  = '0;
            if (y_q < YW'(IMG_H)) y_d = y_q + YW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and pipeline registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      vsync_qq    <= 1'b0;
      href_q      <= 1'b0;
      href_qq     <= 1'b0;
      data_q      <= '0;
      phase_q     <= 1'b0;
      red_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      bcnt_q      <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      ox_q        <= '0;
      oy_q        <= '0;
      sof_q       <= 1'b0;
      fdone_q     <= 1'b0;
      lerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= i_vsync;
      vsync_qq    <= vsync_q;
      href_q      <= i_href;
      href_qq     <= href_q;
      data_q      <= i_data;
      phase_q     <= phase_d;
      red_q       <= red_d;
      x_q         <= x_d;
      y_q         <= y_d;
      bcnt_q      <= bcnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      sof_q       <= sof_d;
      fdone_q     <= fdone_d;
      lerr_q      <= lerr_d;
    end
  end

  assign o_pix_data   = pix_data_q;
  assign o_pix_valid  = pix_valid_q;
  assign o_x          = ox_q;
  assign o_y          = oy_q;
  assign o_sof        = sof_q;
  assign o_frame_done = fdone_q;
  assign o_line_err   = lerr_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb_ov7670_pixel_capture
//   Randomized camera stimulus against a frame/line/pixel reference model.
//   Inputs change on the falling clock edge; outputs are sampled there too.
`timescale 1ns/1ps
module tb_ov7670_pixel_capture;

`ifdef CAPTURE_TESTPAT_EN
  localparam int W = 40;
  localparam int H = 20;
`else
  localparam int W = 4;
  localparam int H = 3;
`endif
  localparam int LB = 2 * W;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cfg = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [11:0] o_pix_data;
  logic        o_pix_valid;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic        o_sof, o_frame_done, o_line_err;

  always #5 clk = ~clk;

  ov7670_pixel_capture #(.IMG_W(W), .IMG_H(H)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_cfg_done(cfg), .i_vsync(vsync), .i_href(href),
    .i_data(data), .o_pix_data(o_pix_data), .o_pix_valid(o_pix_valid), .o_x(o_x),
    .o_y(o_y), .o_sof(o_sof), .o_frame_done(o_frame_done), .o_line_err(o_line_err)
  );

  typedef struct {
    logic [11:0] d;
    int          x;
    int          y;
    logic        sof;
  } pix_t;

  pix_t        expq[$];
  pix_t        mon_e, t4e;
  int          n_checks = 0, n_errors = 0;
  int          exp_fd = 0, exp_le = 0, got_fd = 0, got_le = 0;
  int          m_y = 0;
  bit          m_active = 0, m_cfg = 0;
  bit          first_seen = 0;
  logic [11:0] first_pix = '0;
  logic [7:0]  b4 [4];
  int          nl, len, r;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference pixel value for bytes (b0,b1) at coordinates (x,y)
  function automatic logic [11:0] pix_of(input logic [7:0] b0, input logic [7:0] b1,
                                         input int x, input int y);
`ifdef CAPTURE_TESTPAT_EN
    logic [9:0] xv;
    logic [8:0] yv;
    xv = 10'(x);
    yv = 9'(y);
    return {xv[7:4], yv[7:4], xv[7:4] ^ yv[7:4]};
`else
    return {b0[3:0], b1};
`endif
  endfunction

  // Output monitor: every valid pixel must match the next expected one in order
  always @(negedge clk) begin
    if (rstn) begin
      if (o_frame_done) got_fd++;
      if (o_line_err) got_le++;
      if (o_sof && !o_pix_valid) chk("sof_without_valid", 1, 0);
      if (o_pix_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          first_pix  = o_pix_data;
        end
`ifdef CAPTURE_TESTPAT_EN
        if (o_x == 10'h20 && o_y == 9'h10) chk("testpat_x20_y10", o_pix_data, 12'h213);
`endif
        if (expq.size() == 0) chk("pix_unexpected", 1, 0);
        else begin
          mon_e = expq.pop_front();
          chk("pix_data", o_pix_data, mon_e.d);
          chk("pix_x", o_x, mon_e.x);
          chk("pix_y", o_y, mon_e.y);
          chk("pix_sof", o_sof, mon_e.sof);
        end
      end
    end
  end

  // One HREF line of n bytes; checks valid timing and the line error pulse
  task automatic send_line(input int n, input bit directed);
    logic [7:0] b[$];
    bit         emit[$];
    bit         em, ev, exp_err;
    int         j;
    pix_t       e;
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    if (directed && n >= 4) begin
      b[0] = 8'h0A; b[1] = 8'h5C; b[2] = 8'h03; b[3] = 8'hF1;
    end
    for (int p = 0; p < n / 2; p++) begin
      em = m_active && (p < W) && (m_y < H);
      emit.push_back(em);
      if (em) begin
        e.d   = pix_of(b[2*p], b[2*p+1], p, m_y);
        e.x   = p;
        e.y   = m_y;
        e.sof = (p == 0) && (m_y == 0);
        expq.push_back(e);
      end
    end
    exp_err = m_active && (n > 0) && (n != LB);
    if (exp_err) exp_le++;
    if (m_active && n > 0 && m_y < H) m_y++;
    for (int k = 0; k <= n + 2; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        j  = k - 2;
        ev = (j % 2 == 1) && (j / 2 < emit.size()) && emit[j/2];
        chk("pix_valid_timing", o_pix_valid, ev);
      end
      if (k == n + 1) chk("line_err_early", o_line_err, 0);
      if (k == n + 2) chk("line_err_pulse", o_line_err, exp_err);
      if (k < n) begin
        href = 1'b1;
        data = b[k];
      end else begin
        href = 1'b0;
        data = 8'h00;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  // Vertical blanking pulse between lines
  task automatic vsync_pulse();
    bit ef;
    ef = m_active;
    if (ef) exp_fd++;
    m_active = 0;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); chk("frame_done_early", o_frame_done, 0);
    @(negedge clk); chk("frame_done_pulse", o_frame_done, ef);
    @(negedge clk); chk("frame_done_width", o_frame_done, 0);
    @(negedge clk); vsync = 1'b0;
    if (m_cfg) begin
      m_active = 1;
      m_y      = 0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_pix_data"}, o_pix_data, 0);
    chk({tag, "_pix_valid"}, o_pix_valid, 0);
    chk({tag, "_x"}, o_x, 0);
    chk({tag, "_y"}, o_y, 0);
    chk({tag, "_sof"}, o_sof, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_line_err"}, o_line_err, 0);
  endtask

  initial begin
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cfg = 1'b1; m_cfg = 1;
    repeat (3) @(negedge clk);

    // First frame: directed first line, then full lines
    vsync_pulse();
    send_line(LB, 1);
`ifndef CAPTURE_TESTPAT_EN
    chk("first_pixel_A5C", first_pix, 12'hA5C);
`endif
    for (int l = 1; l < H; l++) send_line(LB, 0);
    vsync_pulse();

    // Short, long and overrun lines
    send_line(LB - 1, 0);
    send_line(LB, 0);
    send_line(LB + 2, 0);
    send_line(LB, 0);
    send_line(LB, 0);
    vsync_pulse();

    // VSYNC rises mid-line, coinciding with the fourth byte
    for (int i = 0; i < 4; i++) b4[i] = 8'($urandom);
    t4e.d = pix_of(b4[0], b4[1], 0, m_y); t4e.x = 0; t4e.y = m_y; t4e.sof = (m_y == 0);
    send_line(LB, 0);
    t4e.d = pix_of(b4[0], b4[1], 0, m_y); t4e.y = m_y; t4e.sof = 1'b0;
    expq.push_back(t4e);
    exp_fd++; m_active = 0;
    @(negedge clk); href = 1'b1; data = b4[0];
    @(negedge clk); data = b4[1];
    @(negedge clk); data = b4[2];
    @(negedge clk); data = b4[3]; vsync = 1'b1;
    @(negedge clk); href = 1'b0; data = 8'h00; chk("midline_fd_early", o_frame_done, 0);
    @(negedge clk); chk("midline_fd_pulse", o_frame_done, 1);
    repeat (3) @(negedge clk);
    vsync = 1'b0; m_active = 1; m_y = 0;
    repeat (3) @(negedge clk);
    send_line(LB, 0);
    send_line(LB, 0);

    // cfg_done drop mid-frame, re-raise mid-frame
    cfg = 1'b0; m_cfg = 0; m_active = 0;
    repeat (2) @(negedge clk);
    send_line(LB, 0);
    cfg = 1'b1; m_cfg = 1;
    repeat (3) @(negedge clk);
    send_line(LB, 0);
    vsync_pulse();
    send_line(LB, 0);

    // Asynchronous reset in the middle of a line
    chk("pre_reset_x", o_x, W - 1);
    @(negedge clk); href = 1'b1; data = 8'hFF;
    @(negedge clk); data = 8'hEE;
    #2 rstn = 1'b0;
    #1 check_outputs_zero("async_reset");
    href = 1'b0; data = 8'h00; m_active = 0;
    @(negedge clk); rstn = 1'b1;
    repeat (3) @(negedge clk);
    vsync_pulse();
    send_line(LB, 0);
    send_line(LB, 0);
    vsync_pulse();

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(H + 1, 1);
      for (int l = 0; l < nl; l++) begin
        r = $urandom_range(5, 0);
        case (r)
          0, 1, 2: len = LB;
          3:       len = LB - 1;
          4:       len = LB + 1;
          default: len = LB - 2;
        endcase
        send_line(len, 0);
      end
      vsync_pulse();
    end

    repeat (4) @(negedge clk);
    chk("pixels_outstanding", expq.size(), 0);
    chk("frame_done_count", got_fd, exp_fd);
    chk("line_err_count", got_le, exp_le);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ov7670_pixel_capture.md
Name: ov7670_pixel_capture

Overview:
- Upstream stage of the grayscale converter, clocked by the OV7670 pixel clock.
- Samples the camera's 8-bit bus (VSYNC/HREF/D), pairs bytes into RGB444 pixels {R[3:0],G[3:0],B[3:0]} and emits them with a single-cycle valid.
- Output drives the grayscale stage's i_data/i_data_valid directly.
- Also tracks pixel/line coordinates, frame boundaries and line-length errors.

Parameters:
IMG_W, 640, active pixels per line (expected HREF width = 2*IMG_W bytes)
IMG_H, 480, active lines per frame

Ports:
i_clk  in  1  camera PCLK; all logic on rising edge
i_rstn  in  1  asynchronous active-low reset
i_cfg_done  in  1  camera SCCB config complete; capture held off until high
i_vsync  in  1  camera VSYNC, high = vertical blanking
i_href  in  1  camera HREF, high = active byte on i_data
i_data  in  8  camera data byte
o_pix_data  out  12  RGB444 pixel {R,G,B}
o_pix_valid  out  1  one-cycle strobe, o_pix_data valid
o_x  out  10  column of pixel on o_pix_data (0..IMG_W-1)
o_y  out  9  row of pixel on o_pix_data (0..IMG_H-1)
o_sof  out  1  high with first valid pixel of a frame (x=0,y=0)
o_frame_done  out  1  one-cycle pulse on VSYNC rising edge after an active frame
o_line_err  out  1  one-cycle pulse: line ended with byte count != 2*IMG_W

Behaviour:
- Reset (async assert, sync release): all outputs 0; FSM IDLE; byte phase 0; x/y counters 0; prev vsync/href registers 0.
- Inputs registered once (i_vsync_q, i_href_q, i_data_q); edge detects use those registers and a second delayed copy.
- FSM IDLE: wait i_cfg_done=1 -> WAIT_FRAME. i_cfg_done dropping in any state -> IDLE, no pulses.
- WAIT_FRAME: ignore HREF; on VSYNC falling edge -> ACTIVE, y=0. A frame already in progress at cfg_done is skipped.
- ACTIVE: while href_q=1, each cycle is one byte. Phase 0 latches R = data_q[3:0] (upper nibble discarded). Phase 1 forms pixel {R, data_q[7:4], data_q[3:0]}.
- Pixel output: o_pix_data/o_pix_valid registered on the edge after the phase-1 byte is in i_data_q. Total latency from i_data pin to o_pix_valid = 2 cycles after the second byte's sampling edge.
- Per-pixel outputs: o_x/o_y hold that pixel's coordinates. o_pix_valid is exactly one cycle; o_pix_data holds its value until the next pixel.
- Counters: x increments after each emitted pixel. On HREF falling edge, x resets to 0 and y increments if at least one byte was seen.
- Line check: if the byte count at HREF fall != 2*IMG_W, pulse o_line_err on the following cycle. An odd trailing byte is discarded. Phase always returns to 0 at HREF fall.
- Overrun: pixels with x>=IMG_W or y>=IMG_H are dropped (no valid). Counters saturate at IMG_W/IMG_H.
- o_sof is asserted together with o_pix_valid when x=0 and y=0.
- VSYNC rising edge in ACTIVE: pulse o_frame_done, drop any half-assembled pixel, y=0, -> WAIT_FRAME.
- VSYNC rise coinciding with an HREF byte: VSYNC wins, the byte is ignored.
- HREF during VSYNC high is ignored in every state.

Optional Feature:
- Macro: CAPTURE_TESTPAT_EN.
- Defined: o_pix_data = {x[7:4], y[7:4], x[7:4]^y[7:4]} using the emitted pixel's coordinates; camera byte values are ignored. Timing, valid, sof, error and frame behaviour are unchanged.
- Undefined: pixel data comes from camera bytes as above, and no pattern logic is synthesised.

Test Plan:
1. Reset, cfg_done=1, VSYNC pulse then one line IMG_W=4 bytes 0x0A,0x5C,0x03,0xF1,... -> pixels 0xA5C, 0x3F1; first with o_sof=1, x=0,y=0; second x=1; valid 2 cycles after second byte edge.
2. Full 4x3 frame (IMG_W=4, IMG_H=3) then VSYNC rise -> 12 valid pulses, y 0..2, one o_frame_done, no o_line_err.
3. Line of 7 bytes -> 3 pixels, last byte dropped, o_line_err pulse one cycle after HREF fall; next line pixel pairing starts at phase 0.
4. VSYNC rises mid-line after 3 bytes -> 1 pixel out, half pixel dropped, o_frame_done=1, next frame starts at y=0 with o_sof.
5. cfg_done low during a frame, then high mid-frame -> no output until after the next VSYNC fall; i_rstn pulsed low mid-line -> outputs 0 immediately (asynchronous).
6. CAPTURE_TESTPAT_EN defined, row y=0x10, x=0x20 -> o_pix_data=0x213.
